// File: rtl/neptuno_joy_pkg.sv
// ----------------------------------------------------------------------------
// neptuno_joy_pkg : shared types and constants for the serial joystick scanner
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package neptuno_joy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_LOAD     = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_SHIFT_HI = 3'd4,
    ST_PUBLISH  = 3'd5
  } state_t;

  localparam logic c_sel_phase0 = 1'b1;
  localparam logic c_sel_phase1 = 1'b0;

  // Ticks in one frame; the single PUBLISH cycle comes on top of this.
  function automatic int unsigned frame_ticks(input int unsigned phases,
                                              input int unsigned settle,
                                              input int unsigned channels,
                                              input int unsigned bits);
    return phases * (settle + 1 + 2 * channels * bits);
  endfunction

endpackage

`default_nettype wire

// File: rtl/neptuno_tick_gen.sv
// ----------------------------------------------------------------------------
// neptuno_tick_gen : free-running divider, one-cycle tick per CLK_DIV clocks
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module neptuno_tick_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic hold,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] c_last = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Holding the count stretches the tick grid by one cycle per held cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (!hold) begin
      cnt_d = (cnt_q == c_last) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == c_last) && !hold;

endmodule

`default_nettype wire

// File: rtl/neptuno_joy_scanner.sv
// ----------------------------------------------------------------------------
// neptuno_joy_scanner : 74x165 joystick chain scanner with atomic frame publish
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module neptuno_joy_scanner
  import neptuno_joy_pkg::*;
#(
  parameter int CLK_DIV      = 16,
  parameter int CHANNELS     = 2,
  parameter int BITS         = 8,
  parameter int PHASES       = 2,
  parameter int SETTLE_TICKS = 2,
  parameter int INVERT       = 1
) (
  input  logic                             CLOCK_50,
  input  logic                             reset_n,
  input  logic                             scan_en,
  input  logic                             JOY_DATA,
  output logic                             JOY_CLK,
  output logic                             JOY_LOAD,
  output logic                             JOY_SEL,
  output logic [CHANNELS*PHASES*BITS-1:0]  joy_out,
  output logic                             frame_valid
);

  localparam int SHIFT_BITS = CHANNELS * BITS;
  localparam int OW         = CHANNELS * PHASES * BITS;
  localparam int BCW        = (SHIFT_BITS > 1) ? $clog2(SHIFT_BITS) : 1;
  localparam int SCW        = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
  localparam logic [BCW-1:0] c_bit_last    = BCW'(SHIFT_BITS - 1);
  localparam logic [SCW-1:0] c_settle_last = SCW'((SETTLE_TICKS > 0) ? SETTLE_TICKS - 1 : 0);
  localparam logic           c_inv         = (INVERT != 0);

  state_t          state_q, state_d;
  logic [BCW-1:0]  bit_q, bit_d;
  logic            phase_q, phase_d;
  logic [SCW-1:0]  settle_q, settle_d;
  logic [OW-1:0]   cap_q, cap_d;
  logic [1:0]      sync_q;
  logic            joy_clk_q, joy_clk_d;
  logic            joy_load_q, joy_load_d;
  logic            joy_sel_q, joy_sel_d;
  logic [OW-1:0]   joy_out_q, joy_out_d;
  logic            frame_valid_q, frame_valid_d;
  logic            tick;
  logic            sample;

  neptuno_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .hold     (state_q == ST_PUBLISH),
    .tick     (tick)
  );

  assign sample = sync_q[1] ^ c_inv;

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    phase_d  = phase_q;
    settle_d = settle_q;
    cap_d    = cap_q;
    case (state_q)
      ST_IDLE: begin
        if (tick && scan_en) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tick) begin
          if (settle_q == c_settle_last) begin
            settle_d = '0;
            state_d  = ST_LOAD;
          end else begin
            settle_d = settle_q + SCW'(1);
          end
        end
      end
      ST_LOAD: begin
        if (tick) state_d = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        if (tick) begin
          // k-th serial bit lands at channel k/BITS, bit BITS-1-(k mod BITS).
          for (int c = 0; c < CHANNELS; c++) begin
            for (int p = 0; p < PHASES; p++) begin
              for (int b = 0; b < BITS; b++) begin
                if (int'(phase_q) == p && int'(bit_q) == c * BITS + BITS - 1 - b) begin
                  cap_d[c*PHASES*BITS + p*BITS + b] = sample;
                end
              end
            end
          end
          state_d = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (tick) begin
          if (bit_q != c_bit_last) begin
            bit_d   = bit_q + BCW'(1);
            state_d = ST_SHIFT_LO;
          end else begin
            bit_d = '0;
            if (PHASES > 1 && phase_q == 1'b0) begin
              phase_d = 1'b1;
              state_d = ST_SETTLE;
            end else begin
              phase_d = 1'b0;
              state_d = ST_PUBLISH;
            end
          end
        end
      end
      ST_PUBLISH: begin
        state_d = scan_en ? ST_SETTLE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pin levels are derived from the next state so they register in step with it.
    joy_clk_d     = (state_d == ST_SHIFT_HI);
    joy_load_d    = (state_d != ST_LOAD);
    joy_sel_d     = phase_d ? c_sel_phase1 : c_sel_phase0;
    frame_valid_d = (state_d == ST_PUBLISH);
    joy_out_d     = (state_d == ST_PUBLISH) ? cap_q : joy_out_q;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      bit_q         <= '0;
      phase_q       <= 1'b0;
      settle_q      <= '0;
      cap_q         <= '0;
      sync_q        <= '0;
      joy_clk_q     <= 1'b0;
      joy_load_q    <= 1'b1;
      joy_sel_q     <= 1'b1;
      joy_out_q     <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_q         <= bit_d;
      phase_q       <= phase_d;
      settle_q      <= settle_d;
      cap_q         <= cap_d;
      sync_q        <= {sync_q[0], JOY_DATA};
      joy_clk_q     <= joy_clk_d;
      joy_load_q    <= joy_load_d;
      joy_sel_q     <= joy_sel_d;
      joy_out_q     <= joy_out_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign JOY_CLK     = joy_clk_q;
  assign JOY_LOAD    = joy_load_q;
  assign JOY_SEL     = joy_sel_q;
  assign joy_out     = joy_out_q;
  assign frame_valid = frame_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_neptuno_joy_scanner.sv
// ----------------------------------------------------------------------------
// tb_neptuno_joy_scanner : scoreboard bench with behavioural 74x165 chains
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_neptuno_joy_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // DUT A: two 8-bit pads, two SEL phases
  logic        rst_a, en_a, data_a, jclk_a, jld_a, jsel_a, fv_a;
  logic [31:0] joy_a;

  neptuno_joy_scanner #(
    .CLK_DIV(4), .CHANNELS(2), .BITS(8), .PHASES(2), .SETTLE_TICKS(2), .INVERT(1)
  ) u_dut_a (
    .CLOCK_50(clk), .reset_n(rst_a), .scan_en(en_a), .JOY_DATA(data_a),
    .JOY_CLK(jclk_a), .JOY_LOAD(jld_a), .JOY_SEL(jsel_a),
    .joy_out(joy_a), .frame_valid(fv_a)
  );

  // DUT B: three 12-bit pads, single phase
  logic        rst_b, en_b, data_b, jclk_b, jld_b, jsel_b, fv_b;
  logic [35:0] joy_b;

  neptuno_joy_scanner #(
    .CLK_DIV(4), .CHANNELS(3), .BITS(12), .PHASES(1), .SETTLE_TICKS(2), .INVERT(1)
  ) u_dut_b (
    .CLOCK_50(clk), .reset_n(rst_b), .scan_en(en_b), .JOY_DATA(data_b),
    .JOY_CLK(jclk_b), .JOY_LOAD(jld_b), .JOY_SEL(jsel_b),
    .joy_out(joy_b), .frame_valid(fv_b)
  );

  // Chain A: ch0 sits next to the data pin, so its MSB leaves first; pins are active-low.
  logic [7:0]  pat_a [2][2];
  logic [15:0] sr_a = '0;
  logic        jclk_prev_a = 1'b0, jld_prev_a = 1'b1, armed_a = 1'b0;
  int          rise_a = 0;

  always @(negedge clk) begin
    if (!rst_a) begin
      rise_a  <= 0;
      armed_a <= 1'b0;
    end else if (!jld_a && jld_prev_a) begin
      if (armed_a) check("rises_per_phase_a", 64'(rise_a), 64'd16);
      armed_a <= 1'b1;
      rise_a  <= 0;
    end else if (jclk_a && !jclk_prev_a) begin
      rise_a <= rise_a + 1;
    end
    if (!jld_a) sr_a <= jsel_a ? {pat_a[0][0], pat_a[0][1]} : {pat_a[1][0], pat_a[1][1]};
    else if (jclk_a && !jclk_prev_a) sr_a <= {sr_a[14:0], 1'b0};
    jclk_prev_a <= jclk_a;
    jld_prev_a  <= jld_a;
  end
  assign data_a = ~sr_a[15];

  logic [11:0] pat_b [3];
  logic [35:0] sr_b = '0;
  logic        jclk_prev_b = 1'b0, jsel_prev_b = 1'b1;
  int          sel_chg_b = 0;

  always @(negedge clk) begin
    if (!jld_b) sr_b <= {pat_b[0], pat_b[1], pat_b[2]};
    else if (jclk_b && !jclk_prev_b) sr_b <= {sr_b[34:0], 1'b0};
    if (jsel_b !== jsel_prev_b) sel_chg_b <= sel_chg_b + 1;
    jclk_prev_b <= jclk_b;
    jsel_prev_b <= jsel_b;
  end
  assign data_b = ~sr_b[35];

  // Scoreboard monitors
  logic [63:0] q_a[$], q_b[$];
  bit per_a = 0, per_b = 0, have_a = 0, have_b = 0;
  int last_a = 0, last_b = 0;

  always @(negedge clk) begin
    if (fv_a) begin
      if (q_a.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_frame_a: actual frame_valid with joy_out %0h, required none", joy_a);
      end else begin
        check("joy_out_a", 64'(joy_a), q_a.pop_front());
      end
      if (per_a && have_a) check("period_a", 64'(cyc - last_a), 64'd281);
      last_a = cyc;
      have_a = 1;
    end
    if (!per_a) have_a = 0;
  end

  always @(negedge clk) begin
    if (fv_b) begin
      if (q_b.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_frame_b: actual frame_valid with joy_out %0h, required none", joy_b);
      end else begin
        check("joy_out_b", 64'(joy_b), q_b.pop_front());
      end
      if (per_b && have_b) check("period_b", 64'(cyc - last_b), 64'd301);
      last_b = cyc;
      have_b = 1;
    end
    if (!per_b) have_b = 0;
  end

  task automatic wait_fv(input bit which_b, input int lim);
    bit got = 0;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge clk);
      if (which_b ? fv_b : fv_a) got = 1;
    end
    if (!got) check(which_b ? "timeout_fv_b" : "timeout_fv_a", 64'd0, 64'd1);
  endtask

  // which=0: JOY_LOAD rising on A; which=1: JOY_SEL falling on A
  task automatic wait_edge(input int which, input int lim);
    logic prev, cur;
    bit got = 0;
    prev = (which == 0) ? jld_a : ~jsel_a;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge clk);
      cur = (which == 0) ? jld_a : ~jsel_a;
      if (cur && !prev) got = 1;
      prev = cur;
    end
    if (!got) check("timeout_edge", 64'd0, 64'd1);
  endtask

  initial begin
    int bad, t0, lat, cnt, lows;
    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
    pat_a[0][0] = 8'h5A; pat_a[0][1] = 8'hC3;
    pat_a[1][0] = 8'h0F; pat_a[1][1] = 8'hF0;
    pat_b[0] = 12'hA53; pat_b[1] = 12'h1F0; pat_b[2] = 12'hC0E;
    repeat (3) @(negedge clk);

    check("rst_joy_clk_a",  64'(jclk_a), 64'd0);
    check("rst_joy_load_a", 64'(jld_a),  64'd1);
    check("rst_joy_sel_a",  64'(jsel_a), 64'd1);
    check("rst_joy_out_a",  64'(joy_a),  64'd0);
    check("rst_fv_a",       64'(fv_a),   64'd0);
    check("rst_joy_out_b",  64'(joy_b),  64'd0);
    check("rst_joy_sel_b",  64'(jsel_b), 64'd1);
    rst_a = 1'b1;
    rst_b = 1'b1;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (jld_a !== 1'b1 || jclk_a !== 1'b0 || jsel_a !== 1'b1 || fv_a !== 1'b0 || joy_a !== 32'h0)
        bad++;
    end
    check("idle_hold_bad_cycles_a", 64'(bad), 64'd0);

    // Continuous scanning with a fixed pattern
    q_a.push_back(64'hF0C3_0F5A);
    per_a = 1;
    t0 = cyc;
    en_a = 1'b1;
    wait_fv(1'b0, 400);
    lat = cyc - t0;
    check("first_latency_a", 64'((lat >= 281 && lat <= 284) ? 281 : lat), 64'd281);
    repeat (2) begin
      q_a.push_back(64'hF0C3_0F5A);
      wait_fv(1'b0, 400);
    end

    // Phase-0 pattern changes after LOAD: this frame keeps the latched data
    q_a.push_back(64'hF0C3_0F5A);
    wait_edge(0, 400);
    check("load_in_phase0_sel", 64'(jsel_a), 64'd1);
    repeat (20) @(negedge clk);
    pat_a[0][0] = 8'h81; pat_a[0][1] = 8'h7E;
    wait_fv(1'b0, 400);
    q_a.push_back(64'hF07E_0F81);
    wait_fv(1'b0, 400);

    // scan_en dropped 10 ticks into phase 1
    q_a.push_back(64'hF07E_0F81);
    wait_edge(1, 400);
    repeat (40) @(negedge clk);
    en_a = 1'b0;
    wait_fv(1'b0, 400);
    per_a = 0;
    cnt = 0; lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (fv_a) cnt++;
      if (!jld_a) lows++;
    end
    check("fv_after_drop_a",   64'(cnt),    64'd0);
    check("load_lows_idle_a",  64'(lows),   64'd0);
    check("idle_sel_a",        64'(jsel_a), 64'd1);
    check("idle_clk_a",        64'(jclk_a), 64'd0);

    // Asynchronous reset mid-shift in phase 1
    en_a = 1'b1;
    wait_edge(1, 400);
    repeat (30) @(negedge clk);
    rst_a = 1'b0;
    #1;
    check("async_rst_sel_a",  64'(jsel_a), 64'd1);
    check("async_rst_load_a", 64'(jld_a),  64'd1);
    check("async_rst_clk_a",  64'(jclk_a), 64'd0);
    check("async_rst_out_a",  64'(joy_a),  64'd0);
    check("async_rst_fv_a",   64'(fv_a),   64'd0);
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    q_a.push_back(64'hF07E_0F81);
    wait_fv(1'b0, 400);
    en_a = 1'b0;

    // Single-phase, three 12-bit pads
    per_b = 1;
    q_b.push_back(64'hC0E_1F0_A53);
    en_b = 1'b1;
    wait_fv(1'b1, 500);
    pat_b[0] = 12'h800; pat_b[1] = 12'h001; pat_b[2] = 12'hFFF;
    q_b.push_back(64'hFFF_001_800);
    wait_fv(1'b1, 500);
    q_b.push_back(64'hFFF_001_800);
    wait_fv(1'b1, 500);
    en_b = 1'b0;
    repeat (20) @(negedge clk);
    check("sel_toggles_b", 64'(sel_chg_b), 64'd0);

    check("pending_a", 64'(q_a.size()), 64'd0);
    check("pending_b", 64'(q_b.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
